// File: rtl/dual_port_sram_param.sv
// dual_port_sram_param: simple-dual-port SRAM with byte enables, 1/2-cycle read latency,
// selectable read-during-write policy and a post-reset clear sequence.
module dual_port_sram_param #(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 8,
  parameter int DEPTH          = 256,
  parameter int READ_LATENCY   = 1,
  parameter int WRITE_FIRST    = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                Clk_In,
  input  logic                Reset_N_In,
  output logic                Ready_Out,
  input  logic                Wr_En_In,
  input  logic [ADDR_W-1:0]   Wr_Addr_In,
  input  logic [DATA_W-1:0]   Wr_Data_In,
  input  logic [DATA_W/8-1:0] Wr_Byte_En_In,
  input  logic                Rd_En_In,
  input  logic [ADDR_W-1:0]   Rd_Addr_In,
  output logic [DATA_W-1:0]   Rd_Data_Out,
  output logic                Rd_Valid_Out
);
  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  typedef enum logic {CLEAR, READY} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic ready_q, ready_d;
  logic rd_vld1_q, rd_vld1_d, rd_vld2_q, rd_vld2_d;
  logic [DATA_W-1:0] rd_data1_q, rd_data1_d, rd_data2_q, rd_data2_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic wr_in, rd_in, wr_ok, rd_ok, col, clr_we;
  logic [DATA_W-1:0] wr_old, wr_word, rd_word;
  always_comb begin
    wr_in = {1'b0, Wr_Addr_In} < DEPTH_L;
    rd_in = {1'b0, Rd_Addr_In} < DEPTH_L;
    wr_ok = ready_q && Wr_En_In && wr_in;
    rd_ok = ready_q && Rd_En_In;
    clr_we = state_q == CLEAR && CLEAR_ON_RESET != 0;
    wr_old = wr_in ? mem[Wr_Addr_In] : '0;
    for (int i = 0; i < NB; i++)
      wr_word[8*i +: 8] = Wr_Byte_En_In[i] ? Wr_Data_In[8*i +: 8] : wr_old[8*i +: 8];
    col = wr_ok && Rd_Addr_In == Wr_Addr_In;
    // Collisions bypass the array so the read sees the merged word this same edge
    rd_word = !rd_in ? '0 : (col && WRITE_FIRST != 0) ? wr_word : mem[Rd_Addr_In];
    state_d = state_q;
    cnt_d = cnt_q;
    ready_d = ready_q;
    if (state_q == CLEAR) begin
      if (CLEAR_ON_RESET == 0 || cnt_q == LAST) begin
        state_d = READY;
        ready_d = 1'b1;
      end else cnt_d = cnt_q + 1'b1;
    end
    rd_vld1_d = rd_ok;
    rd_data1_d = rd_ok ? rd_word : rd_data1_q;
    rd_vld2_d = rd_vld1_q;
    rd_data2_d = rd_vld1_q ? rd_data1_q : rd_data2_q;
  end
  always_ff @(posedge Clk_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      state_q <= CLEAR;
      cnt_q <= '0;
      ready_q <= 1'b0;
      rd_vld1_q <= 1'b0;
      rd_vld2_q <= 1'b0;
      rd_data1_q <= '0;
      rd_data2_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ready_q <= ready_d;
      rd_vld1_q <= rd_vld1_d;
      rd_vld2_q <= rd_vld2_d;
      rd_data1_q <= rd_data1_d;
      rd_data2_q <= rd_data2_d;
    end
  end
  // Array has no reset; writes are suppressed while reset is held
  always_ff @(posedge Clk_In) begin
    if (Reset_N_In) begin
      if (clr_we) mem[cnt_q] <= '0;
      else if (wr_ok) mem[Wr_Addr_In] <= wr_word;
    end
  end
  assign Ready_Out = ready_q;
  assign Rd_Valid_Out = READ_LATENCY == 2 ? rd_vld2_q : rd_vld1_q;
  assign Rd_Data_Out = READ_LATENCY == 2 ? rd_data2_q : rd_data1_q;
endmodule
